// File: rtl/soc_system_pio_pkg.sv
// Shared register map and bit positions for the instruction PIO FIFO.
package soc_system_pio_pkg;

  // Avalon register addresses
  localparam logic [1:0] ADDR_INSTR  = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DONE   = 2'd3;

  // STATUS read layout
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_COUNT = 8;

  // CTRL bits
  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/soc_system_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush. Storage has no reset;
// a per-entry written flag keeps the head output at 0 until a slot is filled.
module soc_system_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  seen;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Flush wins over everything; a push into a full FIFO is only taken alongside a pop
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  assign rdata = seen[rd_ptr] ? mem[rd_ptr] : '0;

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Marks slots that have ever held data so a stale head never reads as X
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     seen <= '0;
    else if (do_push) seen[wr_ptr] <= 1'b1;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/soc_system_pio_instr_fifo.sv
// Avalon-MM instruction PIO: queues HPS writes into a FIFO streamed to the
// coprocessor, counts completions and raises a level interrupt.
module soc_system_pio_instr_fifo
  import soc_system_pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int DONE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              done_pulse,
  output logic              irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DONE_W-1:0] DONE_MAX = '1;

  logic              wr, push, flush, refused;
  logic [CW-1:0]     count;
  logic              empty, full;
  logic              overflow, irq_en;
  logic [DATA_W-1:0] shadow;
  logic [DONE_W-1:0] done_cnt;

  assign wr    = chipselect & ~write_n;
  assign push  = wr & (address == ADDR_INSTR);
  assign flush = wr & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];
  // Full implies valid, so a same-cycle pop is just out_ready
  assign refused   = push & full & ~out_ready;
  assign out_valid = ~empty;

  soc_system_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (out_ready),
    .flush   (flush),
    .wdata   (writedata[DATA_W-1:0]),
    .rdata   (out_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // Control/status registers: shadow of last pushed word, sticky overflow, irq enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push) shadow <= writedata[DATA_W-1:0];
      if (refused) overflow <= 1'b1;
      else if (wr && address == ADDR_STATUS && writedata[ST_OVF]) overflow <= 1'b0;
      if (wr && address == ADDR_CTRL) irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  // Saturating completion counter; a clear racing a pulse keeps that pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           done_cnt <= '0;
    else if (wr && address == ADDR_DONE)    done_cnt <= done_pulse ? DONE_W'(1) : '0;
    else if (done_pulse && done_cnt != DONE_MAX) done_cnt <= done_cnt + DONE_W'(1);
  end

  // Registered interrupt level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_en & (done_cnt != '0);
  end

  // Zero-latency read mux, decoded from address alone
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_INSTR:  readdata[DATA_W-1:0] = shadow;
      ADDR_STATUS: begin
        readdata[ST_EMPTY]      = empty;
        readdata[ST_FULL]       = full;
        readdata[ST_OVF]        = overflow;
        readdata[ST_COUNT +: CW] = count;
      end
      ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en;
      default:     readdata[DONE_W-1:0] = done_cnt;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_instr_fifo.sv
// Directed bench for the instruction PIO FIFO: a vector table for the basic
// register/stream behaviour, then hand sequences for overflow, wrap, flush,
// interrupt, saturation and mid-operation reset.
module tb_soc_system_pio_instr_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done_pulse = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  soc_system_pio_instr_fifo #(.DATA_W(32), .DEPTH(8), .DONE_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done_pulse (done_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic        dp;
    logic [1:0]  raddr;
    logic [31:0] rexp;
    logic        vexp;
    logic [31:0] dexp;
    logic        iexp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus/stream cycle: drive at negedge, release strobes just after posedge
  task automatic cyc(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                     input logic rdy, input logic dp);
    @(negedge clk);
    chipselect = wr; write_n = ~wr; address = a; writedata = wd;
    out_ready = rdy; done_pulse = dp;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0; done_pulse = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  // Stream step against a queue model: check the head on pop, model acceptance on push
  task automatic step(input logic psh, input logic [31:0] wd, input logic rdy, input string name);
    logic popped;
    @(negedge clk);
    chipselect = psh; write_n = ~psh; address = 2'd0; writedata = wd; out_ready = rdy;
    #1;
    popped = 1'b0;
    if (rdy && q.size() != 0) begin
      chk(name, out_data, q[0]);
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (psh && (q.size() < 8 || popped)) q.push_back(wd);
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,     1'b0, 32'h0,  1'b0, "rst_instr"};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd1, 32'h1,     1'b0, 32'h0,  1'b0, "rst_status"};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd2, 32'h0,     1'b0, 32'h0,  1'b0, "rst_ctrl"};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd3, 32'h0,     1'b0, 32'h0,  1'b0, "rst_done"};
    vecs[4]  = '{1'b1, 2'd0, 32'h11, 1'b0, 1'b0, 2'd1, 32'h0100,  1'b1, 32'h11, 1'b0, "push1"};
    vecs[5]  = '{1'b1, 2'd0, 32'h22, 1'b0, 1'b0, 2'd1, 32'h0200,  1'b1, 32'h11, 1'b0, "push2"};
    vecs[6]  = '{1'b1, 2'd0, 32'h33, 1'b0, 1'b0, 2'd1, 32'h0300,  1'b1, 32'h11, 1'b0, "push3"};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 2'd1, 32'h0200,  1'b1, 32'h22, 1'b0, "pop1"};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 2'd1, 32'h0100,  1'b1, 32'h33, 1'b0, "pop2"};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 2'd1, 32'h0001,  1'b0, 32'h0,  1'b0, "pop3"};
    vecs[10] = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h33,    1'b0, 32'h0,  1'b0, "shadow"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven basic behaviour
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].dp);
      address = vecs[i].raddr;
      #1;
      chk({vecs[i].name, "_rd"},    readdata,        vecs[i].rexp);
      chk({vecs[i].name, "_valid"}, 32'(out_valid),  32'(vecs[i].vexp));
      chk({vecs[i].name, "_data"},  out_data,        vecs[i].dexp);
      chk({vecs[i].name, "_irq"},   32'(irq),        32'(vecs[i].iexp));
    end

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, "ovf_fill");
    rd(2'd1, 32'h0806, "ovf_status");
    rd(2'd0, 32'h108,  "ovf_shadow");
    chk("ovf_head", out_data, 32'h100);
    cyc(1'b1, 2'd1, 32'h4, 1'b0, 1'b0);
    rd(2'd1, 32'h0802, "ovf_clear");

    // Full with simultaneous pop and push: count holds, no overflow
    step(1'b1, 32'hAA, 1'b1, "fullpp_head");
    rd(2'd1, 32'h0802, "fullpp_status");
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, "fullpp_order");
    chk("fullpp_empty", 32'(out_valid), 32'h0);

    // Pointer wrap: 20 pushes interleaved with pops
    for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), (i % 3) != 0, "wrap_order");
    rd(2'd1, {16'h0, 8'(q.size()), 8'h0}, "wrap_count");
    for (int i = 0; i < 12 && q.size() != 0; i++) step(1'b0, 32'h0, 1'b1, "wrap_drain");
    chk("wrap_drained", 32'(q.size()), 32'h0);
    chk("wrap_empty", 32'(out_valid), 32'h0);

    // Flush while popping
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 32'h300 + 32'(i), 1'b0, 1'b0);
    chk("flush_pre_head", out_data, 32'h300);
    cyc(1'b1, 2'd2, 32'h1, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    rd(2'd1, 32'h0001, "flush_status");
    rd(2'd2, 32'h0, "flush_selfclear");
    cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    chk("flush_valid2", 32'(out_valid), 32'h0);
    cyc(1'b1, 2'd0, 32'h55, 1'b0, 1'b0);
    chk("flush_repush", out_data, 32'h55);
    rd(2'd1, 32'h0100, "flush_repush_cnt");
    cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);

    // Interrupt and completion counter
    cyc(1'b1, 2'd2, 32'h2, 1'b0, 1'b0);
    rd(2'd2, 32'h2, "irq_en_rd");
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    chk("irq_lat0", 32'(irq), 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("irq_lat1", 32'(irq), 32'h1);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    rd(2'd3, 32'h3, "done_3");
    cyc(1'b1, 2'd3, 32'h0, 1'b0, 1'b1);
    rd(2'd3, 32'h1, "done_clr_pulse");
    chk("irq_hold", 32'(irq), 32'h1);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("irq_hold2", 32'(irq), 32'h1);
    cyc(1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    rd(2'd3, 32'h0, "done_clr");
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("irq_drop", 32'(irq), 32'h0);

    // Saturation at 255
    for (int i = 0; i < 260; i++) cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    rd(2'd3, 32'hFF, "done_sat");
    cyc(1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    rd(2'd3, 32'h0, "done_sat_clr");

    // Asynchronous reset in the middle of activity
    cyc(1'b1, 2'd0, 32'h77, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    rd(2'd1, 32'h1, "arst_status");
    rd(2'd0, 32'h0, "arst_shadow");
    rd(2'd2, 32'h0, "arst_ctrl");
    rd(2'd3, 32'h0, "arst_done");
    @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
